yarp_lsu: RTL and testbench
===========================

Name: yarp_lsu

Overview:
- Load/store unit downstream of the decode control unit.
- Consumes data_req/data_wr/data_byte/zero_extnd together with the ALU-computed address and rs2 data.
- Runs a req/gnt/rvalid transaction on the data-memory bus, generating byte enables and replicated write data.
- Returns aligned, sign- or zero-extended load data to the register-file write mux, stalling the core while the access is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width.
- DATA_W, 32, data bus width; fixed at 32, used for byte-lane math.

Ports:
- Clock and reset:
  - clk  in  1  core clock
  - reset_n  in  1  reset; synchronous to clk, active-low
- Core side:
  - data_req_i  in  1  memory access requested by the current instruction
  - data_wr_i  in  1  1=store, 0=load
  - data_byte_i  in  2  access size (mem_access_t: BYTE=00, HALF_WORD=01, WORD=11; 10 treated as WORD)
  - zero_extnd_i  in  1  1=zero-extend load (LBU/LHU), 0=sign-extend
  - data_addr_i  in  ADDR_W  byte address from ALU
  - data_wdata_i  in  DATA_W  store data (rs2)
  - lsu_stall_o  out  1  hold fetch/decode; access not finished
  - lsu_rdata_o  out  DATA_W  extended load result
  - lsu_rdata_valid_o  out  1  one-cycle pulse: access complete, lsu_rdata_o valid (loads)
  - misalign_o  out  1  misaligned-access pulse; see optional feature
- Memory side:
  - mem_req_o  out  1  bus request
  - mem_we_o  out  1  write enable
  - mem_addr_o  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
  - mem_be_o  out  4  byte enables
  - mem_wdata_o  out  DATA_W  lane-replicated store data
  - mem_gnt_i  in  1  request accepted
  - mem_rvalid_i  in  1  response valid (loads and stores)
  - mem_rdata_i  in  DATA_W  read data, whole word

Behaviour:
- FSM states (lsu_state_t): IDLE, REQ, RESP, DONE.
- IDLE: when data_req_i=1 (and not misaligned-dropped), capture wr/byte/zext/addr/wdata into registers; go to REQ. lsu_stall_o = data_req_i.
- REQ: mem_req_o=1, bus outputs from captured registers; stay until mem_gnt_i=1, then go to RESP. lsu_stall_o=1.
- RESP: mem_req_o=0; wait for mem_rvalid_i. On rvalid, register the extended load data and go to DONE. lsu_stall_o=1.
- DONE: lsu_rdata_valid_o=1 and lsu_stall_o=0 for exactly one cycle; next state IDLE unconditionally. data_req_i is ignored in DONE because the same instruction is still presented.
- Minimum access latency: 4 cycles (accept, gnt, rvalid, done); stall high for 3.
- Byte enables:
  - BYTE: 4'b0001<<addr[1:0]
  - HALF_WORD: 4'b0011<<{addr[1],1'b0}
  - WORD: 4'b1111
  - mem_be_o is driven for loads too.
- Write data: BYTE {4{wdata[7:0]}}; HALF_WORD {2{wdata[15:0]}}; WORD as-is.
- Load data: shift mem_rdata_i right by 8*addr[1:0] (half: 16*addr[1]). Then sign- or zero-extend from bit 7 or 15. WORD passes through; zero_extnd_i is ignored for WORD.
- Stores: lsu_rdata_o is held at its previous value, but lsu_rdata_valid_o still pulses in DONE.
- Bus protocol:
  - mem_rvalid_i never arrives in the same cycle as mem_gnt_i.
  - mem_gnt_i and mem_rvalid_i outside REQ/RESP respectively are ignored.
  - Core inputs are stable while lsu_stall_o=1.
- Reset values: all outputs 0, state IDLE, capture registers 0.
- Reset mid-operation: at the reset edge the FSM returns to IDLE and mem_req_o drops. A late rvalid arriving after reset is ignored.

Optional Feature:
- Macro: YARP_LSU_MISALIGN_CHK_EN.
- Defined:
  - In IDLE, a HALF_WORD with addr[0]=1, or a WORD with addr[1:0]!=0, issues no bus transaction.
  - misalign_o pulses for 1 cycle; lsu_stall_o=0 that cycle.
  - FSM goes to DONE with lsu_rdata_valid_o=0, so the instruction retires and the access is dropped.
- Undefined:
  - misalign_o tied 0.
  - WORD uses the word address with be=1111.
  - HALF_WORD uses addr[1] only, ignoring addr[0].

Decomposition:
- yarp_pkg additions:
  - lsu_state_t enum.
  - BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111.
  - Existing mem_access_t (BYTE/HALF_WORD/WORD) is reused.
- Sub-module yarp_lsu_align: purely combinational; takes size/zext/addr[1:0]/wdata/rdata and produces be, replicated wdata and extended rdata. yarp_lsu holds the FSM and registers.

Test Plan:
- LW at 0x100, gnt after 2 wait cycles, rdata=0xDEADBEEF: mem_addr_o=0x100, be=1111; stall for 5 cycles; lsu_rdata_o=0xDEADBEEF with a 1-cycle valid pulse.
- LB at 0x203, rdata=0x80FF_0011: be=1000, lsu_rdata_o=0xFFFFFF80. LBU at the same address: lsu_rdata_o=0x00000080.
- SH at 0x302, wdata=0x1234ABCD: mem_we_o=1, mem_addr_o=0x300, be=1100, mem_wdata_o=0xABCDABCD; no change to lsu_rdata_o.
- LHU at 0x400, rdata=0x0000F00D: lsu_rdata_o=0x0000F00D; LH at the same address gives 0xFFFFF00D.
- reset_n=0 while in RESP: next cycle state IDLE, mem_req_o=0, stall=0. A subsequent stray rvalid produces no valid pulse.
- With YARP_LSU_MISALIGN_CHK_EN defined, LW at 0x102: no mem_req_o, misalign_o=1 for 1 cycle, lsu_rdata_valid_o=0. Undefined: bus access to 0x100 with be=1111.

Source files
------------

// File: rtl/yarp_lsu_pkg.sv
// Shared types and constants for the yarp load/store unit.
package yarp_lsu_pkg;

    localparam int unsigned LSU_DATA_W = 32;
    localparam int unsigned LSU_BE_W   = LSU_DATA_W / 8;

    // Access size as produced by the decode control unit; 2'b10 behaves as WORD.
    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b11
    } mem_access_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10,
        DONE = 2'b11
    } lsu_state_t;

    localparam logic [LSU_BE_W-1:0] BE_BYTE = 4'b0001;
    localparam logic [LSU_BE_W-1:0] BE_HALF = 4'b0011;
    localparam logic [LSU_BE_W-1:0] BE_WORD = 4'b1111;

    // True when an access of this size cannot be served at this byte offset.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offs);
        logic mis;
        mis = 1'b0;
        if (size == HALF_WORD) begin
            mis = offs[0];
        end else if (size != BYTE) begin
            mis = (offs != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/yarp_lsu_align.sv
// Byte-lane steering: byte enables, store-data replication, load extraction/extension.
module yarp_lsu_align
    import yarp_lsu_pkg::*;
(
    input  logic [1:0]            size_i,
    input  logic                  zext_i,
    input  logic [1:0]            offs_i,
    input  logic [LSU_DATA_W-1:0] wdata_i,
    input  logic [LSU_DATA_W-1:0] rdata_i,
    output logic [LSU_BE_W-1:0]   be_o,
    output logic [LSU_DATA_W-1:0] wdata_o,
    output logic [LSU_DATA_W-1:0] rdata_o
);

    logic [LSU_DATA_W-1:0] rsh_c;

    // Lane selection per access size; anything not BYTE/HALF_WORD is a full word.
    always_comb begin
        be_o    = BE_WORD;
        wdata_o = wdata_i;
        rsh_c   = rdata_i;
        rdata_o = rdata_i;
        case (size_i)
            BYTE: begin
                be_o    = BE_BYTE << offs_i;
                wdata_o = {4{wdata_i[7:0]}};
                rsh_c   = rdata_i >> {offs_i, 3'b000};
                rdata_o = zext_i ? {24'b0, rsh_c[7:0]} : {{24{rsh_c[7]}}, rsh_c[7:0]};
            end
            HALF_WORD: begin
                be_o    = BE_HALF << {offs_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                rsh_c   = rdata_i >> {offs_i[1], 4'b0000};
                rdata_o = zext_i ? {16'b0, rsh_c[15:0]} : {{16{rsh_c[15]}}, rsh_c[15:0]};
            end
            default: begin
                be_o    = BE_WORD;
                wdata_o = wdata_i;
                rsh_c   = rdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/yarp_lsu.sv
// Load/store unit: req/gnt/rvalid data-memory transaction with core stall.
// Optional misaligned-access drop enabled by defining YARP_LSU_MISALIGN_CHK_EN.
module yarp_lsu
    import yarp_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              data_req_i,
    input  logic              data_wr_i,
    input  logic [1:0]        data_byte_i,
    input  logic              zero_extnd_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              lsu_stall_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              lsu_rdata_valid_o,
    output logic              misalign_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    lsu_state_t        state_q, state_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic              zext_q, zext_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_req_q, mem_req_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              valid_q, valid_d;
    logic              misalign_q, misalign_d;
    logic              stall_c;
    logic              misal_c;
    logic [1:0]        size_sel_c;
    logic [1:0]        offs_sel_c;
    logic [3:0]        be_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] ext_c;

`ifdef YARP_LSU_MISALIGN_CHK_EN
    assign misal_c = is_misaligned(data_byte_i, data_addr_i[1:0]);
`else
    // Check disabled: misaligned accesses are forced onto their word/half lanes.
    assign misal_c = 1'b0;
`endif

    // Lane logic sees the live request while idle, the captured access afterwards.
    assign size_sel_c = (state_q == IDLE) ? data_byte_i       : size_q;
    assign offs_sel_c = (state_q == IDLE) ? data_addr_i[1:0]  : addr_q[1:0];

    yarp_lsu_align u_align (
        .size_i  (size_sel_c),
        .zext_i  (zext_q),
        .offs_i  (offs_sel_c),
        .wdata_i (data_wdata_i),
        .rdata_i (mem_rdata_i),
        .be_o    (be_c),
        .wdata_o (wdata_c),
        .rdata_o (ext_c)
    );

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        size_d      = size_q;
        zext_d      = zext_q;
        addr_d      = addr_q;
        mem_req_d   = mem_req_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        valid_d     = 1'b0;
        misalign_d  = 1'b0;
        stall_c     = 1'b0;
        case (state_q)
            IDLE: begin
                stall_c = data_req_i;
                if (data_req_i) begin
                    wr_d        = data_wr_i;
                    size_d      = data_byte_i;
                    zext_d      = zero_extnd_i;
                    addr_d      = data_addr_i;
                    mem_be_d    = be_c;
                    mem_wdata_d = wdata_c;
                    if (misal_c) begin
                        misalign_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        mem_req_d = 1'b1;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                stall_c = 1'b1;
                if (mem_rvalid_i) begin
                    if (!wr_q) begin
                        rdata_d = ext_c;
                    end
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Same instruction is still presented here; its request is not re-accepted.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            size_q      <= 2'b00;
            zext_q      <= 1'b0;
            addr_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            valid_q     <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            size_q      <= size_d;
            zext_q      <= zext_d;
            addr_q      <= addr_d;
            mem_req_q   <= mem_req_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            valid_q     <= valid_d;
            misalign_q  <= misalign_d;
        end
    end

    assign lsu_stall_o       = stall_c;
    assign lsu_rdata_o       = rdata_q;
    assign lsu_rdata_valid_o = valid_q;
    assign misalign_o        = misalign_q;
    assign mem_req_o         = mem_req_q;
    assign mem_we_o          = wr_q;
    assign mem_addr_o        = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_be_o          = mem_be_q;
    assign mem_wdata_o       = mem_wdata_q;

endmodule

// File: tb/tb_yarp_lsu.sv
// Scoreboard bench for yarp_lsu: driver pushes expectations, monitor pops on DUT events.
module tb_yarp_lsu;

    logic        clk;
    logic        reset_n;
    logic        data_req_i;
    logic        data_wr_i;
    logic [1:0]  data_byte_i;
    logic        zero_extnd_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        lsu_stall_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_rdata_valid_o;
    logic        misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic        valid;
        logic        mis;
        logic [31:0] rdata;
        int          stall;
    } resp_exp_t;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          stall_cnt = 0;
    logic [31:0] last_rdata = 32'h0;

    yarp_lsu dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .data_req_i        (data_req_i),
        .data_wr_i         (data_wr_i),
        .data_byte_i       (data_byte_i),
        .zero_extnd_i      (zero_extnd_i),
        .data_addr_i       (data_addr_i),
        .data_wdata_i      (data_wdata_i),
        .lsu_stall_o       (lsu_stall_o),
        .lsu_rdata_o       (lsu_rdata_o),
        .lsu_rdata_valid_o (lsu_rdata_valid_o),
        .misalign_o        (misalign_o),
        .mem_req_o         (mem_req_o),
        .mem_we_o          (mem_we_o),
        .mem_addr_o        (mem_addr_o),
        .mem_be_o          (mem_be_o),
        .mem_wdata_o       (mem_wdata_o),
        .mem_gnt_i         (mem_gnt_i),
        .mem_rvalid_i      (mem_rvalid_i),
        .mem_rdata_i       (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Reference behaviour: which bytes move, from the access size and byte address.
    task automatic do_access(input logic wr, input logic [1:0] size, input logic zext,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int gw, input int rw);
        int          n;
        int          lane;
        logic        mis;
        bus_exp_t    b;
        resp_exp_t   r;
        logic [31:0] v;
        n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        lane = (n == 1) ? int'(addr % 4) : (n == 2) ? int'(addr % 4) / 2 * 2 : 0;
`ifdef YARP_LSU_MISALIGN_CHK_EN
        mis = (n == 2 && addr[0]) || (n == 4 && (addr % 4) != 0);
`else
        mis = 1'b0;
`endif
        b.we    = wr;
        b.addr  = addr - (addr % 4);
        b.be    = 4'(((1 << n) - 1) << lane);
        for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wdata[8*(i % n) +: 8];
        if (n == 4) begin
            v = rdata;
        end else begin
            v = rdata >> (8 * lane);
            if (n == 1) begin
                v = v & 32'h0000_00FF;
                if (!zext && v[7]) v = v | 32'hFFFF_FF00;
            end else begin
                v = v & 32'h0000_FFFF;
                if (!zext && v[15]) v = v | 32'hFFFF_0000;
            end
        end
        if (!wr && !mis) last_rdata = v;
        r.valid = !mis;
        r.mis   = mis;
        r.rdata = last_rdata;
        r.stall = mis ? 1 : gw + rw + 3;
        if (!mis) bus_q.push_back(b);
        resp_q.push_back(r);

        data_req_i   = 1'b1;
        data_wr_i    = wr;
        data_byte_i  = size;
        zero_extnd_i = zext;
        data_addr_i  = addr;
        data_wdata_i = wdata;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        cyc();
        if (!mis) begin
            for (int i = 0; i < gw; i++) begin
                mem_rvalid_i = 1'($urandom % 2);
                cyc();
            end
            mem_rvalid_i = 1'b0;
            mem_gnt_i    = 1'b1;
            cyc();
            mem_gnt_i = 1'b0;
            for (int i = 0; i < rw; i++) begin
                mem_gnt_i = 1'($urandom % 2);
                cyc();
            end
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rdata;
            cyc();
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
        end
        cyc();
        data_req_i = 1'b0;
    endtask

    // Monitor: compares bus handshakes and completion pulses against queued expectations.
    initial begin
        bus_exp_t  b;
        resp_exp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                stall_cnt = 0;
            end else begin
                if (lsu_stall_o) stall_cnt++;
                if (mem_req_o && mem_gnt_i) begin
                    if (bus_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL bus_unexpected: got request to %h, expected none", mem_addr_o);
                    end else begin
                        b = bus_q.pop_front();
                        chk("mem_we",    32'(mem_we_o), 32'(b.we));
                        chk("mem_addr",  mem_addr_o, b.addr);
                        chk("mem_be",    32'(mem_be_o), 32'(b.be));
                        chk("mem_wdata", mem_wdata_o, b.wdata);
                    end
                end
                if (lsu_rdata_valid_o || misalign_o) begin
                    if (resp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL resp_unexpected: got valid=%0d misalign=%0d, expected none",
                                 lsu_rdata_valid_o, misalign_o);
                    end else begin
                        r = resp_q.pop_front();
                        chk("rdata_valid", 32'(lsu_rdata_valid_o), 32'(r.valid));
                        chk("misalign",    32'(misalign_o), 32'(r.mis));
                        chk("lsu_rdata",   lsu_rdata_o, r.rdata);
                        chk("lsu_stall",   lsu_stall_o ? 32'd1 : 32'd0, 32'd0);
                        chk("stall_cycles", 32'(stall_cnt), 32'(r.stall));
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] sz;
        reset_n      = 1'b0;
        data_req_i   = 1'b0;
        data_wr_i    = 1'b0;
        data_byte_i  = 2'b00;
        zero_extnd_i = 1'b0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        repeat (3) cyc();
        chk("rst_req",   32'(mem_req_o), 32'd0);
        chk("rst_stall", 32'(lsu_stall_o), 32'd0);
        chk("rst_valid", 32'(lsu_rdata_valid_o), 32'd0);
        chk("rst_mis",   32'(misalign_o), 32'd0);
        chk("rst_rdata", lsu_rdata_o, 32'd0);
        chk("rst_be",    32'(mem_be_o), 32'd0);
        chk("rst_addr",  mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_we",    32'(mem_we_o), 32'd0);
        reset_n = 1'b1;
        cyc();

        // Directed accesses.
        do_access(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 2, 0);
        do_access(1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0,         32'h80FF_0011, 0, 0);
        do_access(1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0,         32'h80FF_0011, 1, 1);
        do_access(1'b1, 2'b01, 1'b0, 32'h0000_0302, 32'h1234_ABCD, 32'h5555_5555, 0, 2);
        do_access(1'b0, 2'b01, 1'b1, 32'h0000_0400, 32'h0,         32'h0000_F00D, 0, 0);
        do_access(1'b0, 2'b01, 1'b0, 32'h0000_0400, 32'h0,         32'h0000_F00D, 0, 0);
        do_access(1'b0, 2'b11, 1'b0, 32'h0000_0102, 32'h0,         32'hCAFE_F00D, 1, 0);
        do_access(1'b0, 2'b01, 1'b0, 32'h0000_0201, 32'h0,         32'h8001_7F02, 0, 0);
        cyc();

        // Reset while waiting for rvalid, then a stray rvalid.
        bus_q.push_back('{we: 1'b0, addr: 32'h0000_0500, be: 4'b1111, wdata: 32'h0});
        data_req_i   = 1'b1;
        data_wr_i    = 1'b0;
        data_byte_i  = 2'b11;
        zero_extnd_i = 1'b0;
        data_addr_i  = 32'h0000_0500;
        data_wdata_i = 32'h0;
        cyc();
        mem_gnt_i = 1'b1;
        cyc();
        mem_gnt_i = 1'b0;
        reset_n   = 1'b0;
        cyc();
        reset_n    = 1'b1;
        data_req_i = 1'b0;
        last_rdata = 32'h0;
        #1;
        chk("rstmid_req",   32'(mem_req_o), 32'd0);
        chk("rstmid_stall", 32'(lsu_stall_o), 32'd0);
        chk("rstmid_rdata", lsu_rdata_o, 32'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1111_2222;
        cyc();
        mem_rvalid_i = 1'b0;
        chk("stray_valid", 32'(lsu_rdata_valid_o), 32'd0);
        cyc();
        chk("stray_valid2", 32'(lsu_rdata_valid_o), 32'd0);
        chk("stray_stall",  32'(lsu_stall_o), 32'd0);

        // Randomized accesses.
        for (int k = 0; k < 60; k++) begin
            sz = 2'($urandom % 4);
            do_access(1'($urandom % 2), sz, 1'($urandom % 2), $urandom, $urandom, $urandom,
                      int'($urandom % 4), int'($urandom % 4));
            repeat ($urandom % 3) cyc();
        end
        repeat (4) cyc();
        chk("bus_q_drained",  32'(bus_q.size()), 32'd0);
        chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
